ga_fitness_eval: RTL and testbench
==================================

// Module: ga_fitness_eval
// PURPOSE
//  Synthesizable fitness stage for the GA engine. Receives one chromosome at a time as a
//  byte-serial gene stream. Compares each gene to the target string and counts matches.
//  Converts the count to an integer percentage with a shift-subtract divider, then returns
//  {id, score, percent} on a valid/ready result channel. Sits between the population
//  generator/mutator (upstream) and the parent-selection logic (downstream). Also tracks
//  the running best percentage for convergence detection.
// PARAMETERS
//  LEN      12              genes per chromosome (>=2)
//  GENE_W   8               bits per gene (ASCII char)
//  ID_W     4               width of individual tag carried through
//  TARGET   "Hello World!"  LEN*GENE_W packed target; gene 0 = most-significant byte
// PORTS
//  clk          in   1         rising-edge clock
//  rst_n        in   1         asynchronous, active-low reset
//  in_valid     in   1         gene beat valid
//  in_ready     out  1         stage accepts a gene beat
//  in_gene      in   GENE_W    gene value
//  in_last      in   1         final gene of chromosome
//  in_id        in   ID_W      individual tag; sampled on first beat of record
//  out_valid    out  1         result valid
//  out_ready    in   1         downstream accepts result
//  out_id       out  ID_W      tag of evaluated individual
//  out_score    out  SW        match count, SW=$clog2(LEN+1)
//  out_percent  out  7         floor(score*100/LEN), 0..100
//  out_err      out  1         record length != LEN
//  clr_best     in   1         synchronous clear of best tracker
//  best_percent out  7         max out_percent seen since reset/clr_best
//  best_id      out  ID_W      tag that produced best_percent (first one wins ties)
// BEHAVIOUR
//  - Reset (async, rst_n=0) values:
//    - state=ACCUM, in_ready=1, out_valid=0, out_id/out_score/out_percent/out_err=0.
//    - best_percent=0, best_id=0, gene index=0, score=0.
//  - in_ready = (state==ACCUM), combinational from state. Beat accepted when in_valid&&in_ready.
//    in_valid gaps are allowed; the index advances only on accepted beats.
//  - ACCUM: on each accepted beat, score += (in_gene == TARGET byte[idx]) and idx++.
//    - Record ends on a beat with in_last=1, or on beat idx==LEN-1, whichever comes first.
//    - out_err=1 if in_last was not asserted exactly on idx==LEN-1:
//      - Early end: missing genes count as mismatches.
//      - Forced end at LEN beats without in_last: the next beat starts a new record.
//    - At record end: latch id, go to DIVIDE, clear idx.
//  - DIVIDE: restoring shift-subtract divide of P=score*100 by LEN.
//    - One quotient bit per cycle, PW=$clog2(LEN*100+1) cycles (LEN=12 -> 11 cycles).
//    - The quotient is truncated to 7 bits, which is always <=100.
//  - OUT: out_valid=1. out_* are held stable until out_ready.
//    - On the handshake: go to ACCUM and clear score.
//    - If out_ready is already high when out_valid rises, the handshake completes in that
//      same cycle.
//  - Latency: out_valid rises exactly PW+1 rising edges after the edge that accepts the
//    final beat. No record overlap: in_ready=0 through DIVIDE and OUT.
//  - Best tracker:
//    - Updates on each result handshake when out_percent > best_percent (strict, so ties
//      keep the older id).
//    - clr_best zeros best_percent/best_id next edge; if it coincides with a handshake,
//      the clear wins.
//  - Reset mid-record or mid-divide: the partial record is discarded, no result is emitted,
//    and the block restarts in ACCUM.
// TESTING
//  1. Stream "Hello World!" id=3, in_last on beat 11, out_ready=1
//     -> score=12, percent=100, err=0, id=3; out_valid 12 edges after last beat; best=100/3.
//  2. "Hellx World?" id=5
//     -> score=10, percent=83, err=0.
//  3. Twelve 0x20 (spaces)
//     -> score=1, percent=8.
//  4. Record 2, then hold out_ready=0 for 20 cycles
//     -> out_valid held, outputs stable, in_ready=0 while a new record is offered;
//        release -> handshake, in_ready=1 next cycle.
//  5. "Hello" with in_last on beat 4
//     -> score=5, percent=41, err=1; then 13 beats with no in_last
//        -> first 12 form a record with err=1, 13th starts the next record.
//  6. Assert rst_n low on beat 6 of a record, release, send record 1
//     -> single result score=12, no stale output; pulse clr_best -> best_percent=0, best_id=0.

Source files
------------

// File: rtl/ga_fitness_eval.sv
// ga_fitness_eval
//   Fitness stage of the GA engine. Accepts one chromosome as a byte-serial
//   gene stream, counts genes that match TARGET, converts the count into an
//   integer percentage with a restoring shift-subtract divider and presents
//   {id, score, percent, err} on a valid/ready result channel. A running
//   best-percentage tracker supports convergence detection.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_in_valid/o_in_ready       gene beat handshake
//   i_in_gene, i_in_last        gene value, final gene of chromosome
//   i_in_id                     individual tag, sampled on first beat
//   o_out_valid/i_out_ready     result handshake
//   o_out_id, o_out_score       tag and match count of evaluated individual
//   o_out_percent               floor(score*100/LEN)
//   o_out_err                   record length differed from LEN
//   i_clr_best                  synchronous clear of the best tracker
//   o_best_percent, o_best_id   best result since reset/clear
module ga_fitness_eval #(
  parameter int LEN = 12,
  parameter int GENE_W = 8,
  parameter int ID_W = 4,
  parameter logic [LEN*GENE_W-1:0] TARGET = "Hello World!",
  localparam int SW = $clog2(LEN+1),
  localparam int PW = $clog2(LEN*100+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [GENE_W-1:0] i_in_gene,
  input  logic              i_in_last,
  input  logic [ID_W-1:0]   i_in_id,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ID_W-1:0]   o_out_id,
  output logic [SW-1:0]     o_out_score,
  output logic [6:0]        o_out_percent,
  output logic              o_out_err,
  input  logic              i_clr_best,
  output logic [6:0]        o_best_percent,
  output logic [ID_W-1:0]   o_best_id
);

  localparam int IW = $clog2(LEN);
  localparam int RW = IW + 1;
  localparam int CW = $clog2(PW+1);

  typedef enum logic [1:0] {ACCUM, DIVIDE, OUT} state_t;

  state_t            r_state, w_state_next;
  logic [IW-1:0]     r_idx;
  logic [SW-1:0]     r_score;
  logic [ID_W-1:0]   r_first_id;
  logic [PW-1:0]     r_div;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [IW-1:0]     r_rem;
  logic [CW-1:0]     r_cnt;
  logic [ID_W-1:0]   r_out_id;
  logic [SW-1:0]     r_out_score;
  logic [6:0]        r_out_percent;
  logic              r_out_err;
  logic [6:0]        r_best_percent;
  logic [ID_W-1:0]   r_best_id;

  // Target unpacked so gene 0 is the most-significant byte.
  logic [GENE_W-1:0] w_tgt [LEN];
  for (genvar gi = 0; gi < LEN; gi++) begin : g_tgt
    assign w_tgt[gi] = TARGET[(LEN-1-gi)*GENE_W +: GENE_W];
  end

  logic              w_accept;
  logic              w_at_last_idx;
  logic              w_rec_end;
  logic [SW-1:0]     w_score_next;
  logic [PW-1:0]     w_prod;
  logic [RW-1:0]     w_trial;
  logic              w_trial_ge;
  logic [RW-1:0]     w_trial_sub;
  logic              w_div_done;
  logic              w_hs;

  assign o_in_ready    = (r_state == ACCUM);
  assign o_out_valid   = (r_state == OUT);
  assign w_accept      = i_in_valid && o_in_ready;
  assign w_at_last_idx = (r_idx == IW'(LEN-1));
  assign w_rec_end     = w_accept && (i_in_last || w_at_last_idx);
  assign w_score_next  = r_score + SW'(i_in_gene == w_tgt[r_idx]);
  assign w_prod        = PW'(w_score_next) * PW'(100);
  assign w_trial       = {r_rem, r_div[PW-1]};
  assign w_trial_ge    = (w_trial >= RW'(LEN));
  assign w_trial_sub   = w_trial - RW'(LEN);
  assign w_div_done    = (r_cnt == CW'(PW));
  assign w_hs          = o_out_valid && i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM:   if (w_rec_end)  w_state_next = DIVIDE;
      DIVIDE:  if (w_div_done) w_state_next = OUT;
      OUT:     if (w_hs)       w_state_next = ACCUM;
      default:                 w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_score       <= '0;
      r_first_id    <= '0;
      r_div         <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
      r_out_id      <= '0;
      r_out_score   <= '0;
      r_out_percent <= '0;
      r_out_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_score <= w_score_next;
        if (r_idx == '0) r_first_id <= i_in_id;
        if (w_rec_end) begin
          r_idx       <= '0;
          // A single-beat record carries its tag on this very beat.
          r_out_id    <= (r_idx == '0) ? i_in_id : r_first_id;
          r_out_score <= w_score_next;
          r_out_err   <= !(i_in_last && w_at_last_idx);
          r_div       <= w_prod;
          r_rem       <= '0;
          r_cnt       <= '0;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
      // PW quotient steps, then one extra cycle to publish the result.
      if (r_state == DIVIDE) begin
        if (w_div_done) begin
          r_out_percent <= r_div[6:0];
        end else begin
          r_cnt <= r_cnt + CW'(1);
          r_div <= {r_div[PW-2:0], w_trial_ge};
          r_rem <= w_trial_ge ? w_trial_sub[IW-1:0] : w_trial[IW-1:0];
        end
      end
      if (w_hs) r_score <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_percent <= '0;
      r_best_id      <= '0;
    end else if (i_clr_best) begin
      r_best_percent <= '0;
      r_best_id      <= '0;
    end else if (w_hs && (r_out_percent > r_best_percent)) begin
      r_best_percent <= r_out_percent;
      r_best_id      <= r_out_id;
    end
  end

  assign o_out_id       = r_out_id;
  assign o_out_score    = r_out_score;
  assign o_out_percent  = r_out_percent;
  assign o_out_err      = r_out_err;
  assign o_best_percent = r_best_percent;
  assign o_best_id      = r_best_id;

endmodule

// File: tb/tb_ga_fitness_eval.sv
// tb_ga_fitness_eval
//   Directed-vector bench for ga_fitness_eval. Stimulus pushes the expected
//   result of each record into a queue; a monitor pops and compares whenever
//   the DUT completes a result handshake, and checks result latency.
module tb_ga_fitness_eval;

  localparam int SW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [7:0]  i_in_gene = '0;
  logic        i_in_last = 1'b0;
  logic [3:0]  i_in_id = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b1;
  logic [3:0]  o_out_id;
  logic [SW-1:0] o_out_score;
  logic [6:0]  o_out_percent;
  logic        o_out_err;
  logic        i_clr_best = 1'b0;
  logic [6:0]  o_best_percent;
  logic [3:0]  o_best_id;

  ga_fitness_eval dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_gene(i_in_gene),
    .i_in_last(i_in_last), .i_in_id(i_in_id),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_id(o_out_id), .o_out_score(o_out_score), .o_out_percent(o_out_percent),
    .o_out_err(o_out_err), .i_clr_best(i_clr_best),
    .o_best_percent(o_best_percent), .o_best_id(o_best_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int score;
    int pct;
    int err;
    int rise;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not met (cycle %0d)", nm, cyc);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [7:0] g, input logic last, input logic [3:0] id);
    int t = 0;
    i_in_valid = 1'b1;
    i_in_gene  = g;
    i_in_last  = last;
    i_in_id    = id;
    forever begin
      @(negedge clk);
      if (o_in_ready) break;
      t++;
      if (t > 200) begin
        fail_now("in_ready_timeout");
        break;
      end
    end
    last_acc = cyc + 1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
  endtask

  // Sends beats 0..n-1 of s; in_last on beat last_at (-1: never). Only the
  // first beat carries the real id, later beats carry a decoy tag.
  task automatic send_record(input logic [95:0] s, input int n, input int last_at,
                             input logic [3:0] id, input bit gap);
    for (int i = 0; i < n; i++) begin
      send_beat(s[(11-i)*8 +: 8], (i == last_at), (i == 0) ? id : ~id);
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic push_exp(input int id, input int score, input int pct, input int err);
    exp_t e;
    e.id = id; e.score = score; e.pct = pct; e.err = err;
    e.rise = last_acc + 12;
    q.push_back(e);
  endtask

  task automatic drain;
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) fail_now("drain_timeout");
    @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor / scoreboard.
  initial begin : monitor
    bit   prev_v = 1'b0;
    bit   chk_low = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v  = 1'b0;
        chk_low = 1'b0;
      end else begin
        if (chk_low) begin
          chk("valid_drop", int'(o_out_valid), 0);
          chk_low = 1'b0;
        end
        if (o_out_valid && !prev_v) begin
          if (q.size() == 0) fail_now("unexpected_valid");
          else chk("latency", cyc, q[0].rise);
        end
        if (o_out_valid && i_out_ready) begin
          if (q.size() == 0) begin
            fail_now("unexpected_result");
          end else begin
            e = q.pop_front();
            chk("out_id", int'(o_out_id), e.id);
            chk("out_score", int'(o_out_score), e.score);
            chk("out_percent", int'(o_out_percent), e.pct);
            chk("out_err", int'(o_out_err), e.err);
            $display("result id=%0d score=%0d percent=%0d err=%0d", o_out_id,
                     o_out_score, o_out_percent, o_out_err);
          end
          chk_low = 1'b1;
        end
        prev_v = o_out_valid;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [95:0] hello;
    logic [95:0] hellx;
    logic [95:0] spaces;
    logic [3:0]  s_id;
    logic [SW-1:0] s_score;
    logic [6:0]  s_pct;
    logic        s_err;
    bit          have_snap;
    hello  = "Hello World!";
    hellx  = "Hellx World?";
    spaces = {12{8'h20}};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", int'(o_in_ready), 1);
    chk("rst_out_valid", int'(o_out_valid), 0);
    chk("rst_out_score", int'(o_out_score), 0);
    chk("rst_best_pct", int'(o_best_percent), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: exact match
    send_record(hello, 12, 11, 4'd3, 1'b0);
    push_exp(3, 12, 100, 0);
    drain();
    chk("best_pct_t1", int'(o_best_percent), 100);
    chk("best_id_t1", int'(o_best_id), 3);
    @(posedge clk); #1;

    // 2: two mismatches, with idle gaps between beats
    send_record(hellx, 12, 11, 4'd5, 1'b1);
    push_exp(5, 10, 83, 0);
    drain();
    @(posedge clk); #1;

    // 3: all spaces, one match at index 5
    send_record(spaces, 12, 11, 4'd6, 1'b0);
    push_exp(6, 1, 8, 0);
    drain();
    chk("best_pct_t3", int'(o_best_percent), 100);
    chk("best_id_t3", int'(o_best_id), 3);
    @(posedge clk); #1;

    // 4: backpressure
    i_out_ready = 1'b0;
    send_record(hellx, 12, 11, 4'd10, 1'b0);
    push_exp(10, 10, 83, 0);
    i_in_valid = 1'b1;
    i_in_gene  = "H";
    have_snap  = 1'b0;
    s_id = '0; s_score = '0; s_pct = '0; s_err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(o_in_ready), 0);
      if (o_out_valid) begin
        if (!have_snap) begin
          have_snap = 1'b1;
          s_id = o_out_id; s_score = o_out_score; s_pct = o_out_percent; s_err = o_out_err;
        end else begin
          chk("bp_hold_id", int'(o_out_id), int'(s_id));
          chk("bp_hold_pct", int'(o_out_percent), int'(s_pct));
          chk("bp_hold_score_err", int'({o_out_score, o_out_err}), int'({s_score, s_err}));
        end
      end
    end
    chk("bp_valid_held", int'(o_out_valid), 1);
    @(posedge clk); #1;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", int'(o_in_ready), 1);
    drain();
    @(posedge clk); #1;

    // 5: short record, forced record, then a record starting on the 13th beat
    send_record(hello, 5, 4, 4'd4, 1'b0);
    push_exp(4, 5, 41, 1);
    send_record(hello, 12, -1, 4'd7, 1'b0);
    push_exp(7, 12, 100, 1);
    send_record(hello, 12, 11, 4'd9, 1'b0);
    push_exp(9, 12, 100, 0);
    drain();
    chk("best_id_tie", int'(o_best_id), 3);
    @(posedge clk); #1;

    // 6: reset mid-record, then a clean record and a best clear
    send_record(hello, 6, -1, 4'd2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(o_in_ready), 1);
    chk("mid_rst_out_valid", int'(o_out_valid), 0);
    chk("mid_rst_out_id", int'(o_out_id), 0);
    chk("mid_rst_out_pct", int'(o_out_percent), 0);
    chk("mid_rst_best_pct", int'(o_best_percent), 0);
    chk("mid_rst_best_id", int'(o_best_id), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_record(hello, 12, 11, 4'd11, 1'b0);
    push_exp(11, 12, 100, 0);
    drain();
    chk("best_pct_t6", int'(o_best_percent), 100);
    chk("best_id_t6", int'(o_best_id), 11);
    @(posedge clk); #1;
    i_clr_best = 1'b1;
    @(posedge clk); #1;
    i_clr_best = 1'b0;
    @(negedge clk);
    chk("clr_best_pct", int'(o_best_percent), 0);
    chk("clr_best_id", int'(o_best_id), 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) fail_now("leftover_expected");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
